// File: rtl/dram_lsu_bridge.sv
// Load/store bridge between the core memory stage and a single-port word RAM:
// byte/half/word access with sign/zero extension, ALE detection and read-modify-write for sub-word stores.
module dram_lsu_bridge #(
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int TRACE_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_ale_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [31:0]       mem_d_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_spo_i,
  output logic              dbg_we_o,
  output logic [31:0]       dbg_addr_o,
  output logic [31:0]       dbg_data_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              ale_q;
  logic              misaligned;
  logic              unused_addr_hi;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00: m[{lane, 3'b000} +: 8] = d[7:0];
      2'b01: begin
        if (lane[1]) m[31:16] = d[15:0];
        else         m[15:0]  = d[15:0];
      end
      default: m = d;
    endcase
    return m;
  endfunction

  assign misaligned = (req_size_i == 2'b11) ||
                      (req_size_i == 2'b01 && req_addr_i[0]) ||
                      (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

  // Byte address wraps modulo the RAM size, so the high bits are dropped.
  assign unused_addr_hi = &{1'b0, req_addr_i[31:ADDR_W+2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      ale_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i[ADDR_W+1:0];
            wdata_q <= req_wdata_i;
            cnt_q   <= '0;
            rdata_q <= '0;
            ale_q   <= misaligned;
            if (misaligned) begin
              state_q <= RESP;
            end else if (req_we_i && req_size_i == 2'b10) begin
              word_q  <= req_wdata_i;
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          // RAM word is valid in the MEM_LAT-th cycle after mem_a settled.
          if (cnt_q == CW'(MEM_LAT)) begin
            if (we_q) begin
              word_q  <= store_merge(mem_spo_i, wdata_q, size_q, addr_q[1:0]);
              state_q <= WR;
            end else begin
              rdata_q <= load_ext(mem_spo_i, size_q, uns_q, addr_q[1:0]);
              state_q <= RESP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR: state_q <= RESP;
        RESP: begin
          rdata_q <= '0;
          ale_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = !rst_i && state_q == IDLE;
  assign rsp_valid_o = !rst_i && state_q == RESP;
  assign rsp_ale_o   = rsp_valid_o && ale_q;
  assign rsp_rdata_o = rst_i ? 32'h0 : rdata_q;
  assign mem_a_o     = rst_i ? '0 : addr_q[ADDR_W+1:2];
  assign mem_d_o     = rst_i ? 32'h0 : word_q;
  assign mem_we_o    = !rst_i && state_q == WR;

  if (TRACE_EN != 0) begin : g_trace
    assign dbg_we_o   = mem_we_o;
    assign dbg_addr_o = 32'({mem_a_o, 2'b00});
    assign dbg_data_o = mem_d_o;
  end else begin : g_no_trace
    assign dbg_we_o   = 1'b0;
    assign dbg_addr_o = 32'h0;
    assign dbg_data_o = 32'h0;
  end

endmodule

// File: tb/tb_dram_lsu_bridge.sv
// Directed bench: instance 0 has MEM_LAT=1 for the functional tests, instances 1/2 (MEM_LAT 0/3) for back-to-back.
module tb_dram_lsu_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic [2:0] req_valid = '0;
  logic req_we = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0] req_ready, rsp_valid, rsp_ale, mem_we, dbg_we;
  logic [2:0][31:0] rsp_rdata, mem_d, mem_spo, dbg_addr, dbg_data;
  logic [2:0][7:0] mem_a;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] ram [256];

    dram_lsu_bridge #(.ADDR_W(8), .MEM_LAT(LAT), .TRACE_EN(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[g]),
      .rsp_rdata_o(rsp_rdata[g]), .rsp_ale_o(rsp_ale[g]), .mem_a_o(mem_a[g]),
      .mem_d_o(mem_d[g]), .mem_we_o(mem_we[g]), .mem_spo_i(mem_spo[g]),
      .dbg_we_o(dbg_we[g]), .dbg_addr_o(dbg_addr[g]), .dbg_data_o(dbg_data[g])
    );

    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        ram[4] <= 32'h8899_AABB;
      end else if (mem_we[g]) begin
        ram[mem_a[g]] <= mem_d[g];
      end
    end

    if (LAT == 0) begin : g_comb
      assign mem_spo[g] = ram[mem_a[g]];
    end else begin : g_reg
      logic [31:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= ram[mem_a[g]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_spo[g] = pipe[LAT-1];
    end
  end

  // One request on instance inst; lat is the cycle of rsp_valid counted from the accept edge.
  task automatic do_req(input int inst, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic ale, output int wecnt,
                        output logic [31:0] md, output logic [31:0] da, output logic [31:0] dd);
    @(negedge clk);
    req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
    req_valid[inst] = 1'b1;
    @(posedge clk);
    #1 req_valid[inst] = 1'b0;
    lat = -1; rd = '0; ale = 1'b0; wecnt = 0; md = '0; da = '0; dd = '0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (mem_we[inst] || dbg_we[inst]) begin
        wecnt++; md = mem_d[inst]; da = dbg_addr[inst]; dd = dbg_data[inst];
      end
      if (rsp_valid[inst]) begin
        lat = n; rd = rsp_rdata[inst]; ale = rsp_ale[inst];
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_ale, mem_we, dbg_we} !== 15'h0) begin
      bad++; $display("FAIL reset_ctrl: got %h want 0", {req_ready, rsp_valid, rsp_ale, mem_we, dbg_we});
    end
    total++;
    if ({mem_a, mem_d, rsp_rdata, dbg_addr, dbg_data} !== '0) begin
      bad++; $display("FAIL reset_data: got nonzero, mem_a=%h mem_d=%h", mem_a, mem_d);
    end
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b111) begin
      bad++; $display("FAIL reset_ready: got %b want 111", req_ready);
    end
  endtask

  task automatic test_loads();
    int lat, wc; logic [31:0] rd, md, da, dd; logic ale;
    logic [31:0] addrs [4] = '{32'h13, 32'h12, 32'h12, 32'h10};
    logic [1:0]  szs   [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps  [4] = '{32'hFFFF_FF88, 32'h0000_8899, 32'hFFFF_8899, 32'h8899_AABB};
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, szs[i], unss[i], addrs[i], 32'h0, lat, rd, ale, wc, md, da, dd);
      total++;
      if (rd !== exps[i] || ale !== 1'b0) begin
        bad++; $display("FAIL load%0d_data: got %h ale=%b want %h ale=0", i, rd, ale, exps[i]);
      end
      total++;
      if (lat != 3 || wc != 0) begin
        bad++; $display("FAIL load%0d_lat: got lat=%0d we=%0d want lat=3 we=0", i, lat, wc);
      end
    end
  endtask

  task automatic test_stores();
    int lat, wc; logic [31:0] rd, md, da, dd; logic ale;
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055, lat, rd, ale, wc, md, da, dd);
    total++;
    if (wc != 1 || md !== 32'h8899_55BB) begin
      bad++; $display("FAIL stb_write: got we=%0d mem_d=%h want 1 889955bb", wc, md);
    end
    total++;
    if (da !== 32'h10 || dd !== 32'h8899_55BB) begin
      bad++; $display("FAIL stb_trace: got %h/%h want 00000010/889955bb", da, dd);
    end
    total++;
    if (lat != 4 || rd !== 32'h0 || ale !== 1'b0) begin
      bad++; $display("FAIL stb_rsp: got lat=%0d rd=%h ale=%b want 4 0 0", lat, rd, ale);
    end
    do_req(0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_ABCD, lat, rd, ale, wc, md, da, dd);
    total++;
    if (wc != 1 || md !== 32'hABCD_0005 || lat != 4) begin
      bad++; $display("FAIL sth: got we=%0d mem_d=%h lat=%0d want 1 abcd0005 4", wc, md, lat);
    end
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, lat, rd, ale, wc, md, da, dd);
    total++;
    if (wc != 1 || md !== 32'hCAFE_F00D || lat != 2 || da !== 32'h18) begin
      bad++; $display("FAIL stw: got we=%0d mem_d=%h lat=%0d da=%h want 1 cafef00d 2 18", wc, md, lat, da);
    end
    // 0x410 aliases 0x10 with an 8-bit word address.
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h410, 32'h0, lat, rd, ale, wc, md, da, dd);
    total++;
    if (rd !== 32'h8899_55BB) begin
      bad++; $display("FAIL wrap_read: got %h want 889955bb", rd);
    end
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, lat, rd, ale, wc, md, da, dd);
    total++;
    if (rd !== 32'hFFFF_ABCD) begin
      bad++; $display("FAIL sth_readback: got %h want ffffabcd", rd);
    end
  endtask

  task automatic test_ale();
    int lat, wc; logic [31:0] rd, md, da, dd; logic ale;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  szs  [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] adrs [3] = '{32'h12, 32'h21, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_req(0, wes[i], szs[i], 1'b0, adrs[i], 32'hFFFF_FFFF, lat, rd, ale, wc, md, da, dd);
      total++;
      if (ale !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
        bad++; $display("FAIL ale%0d: got ale=%b rd=%h lat=%0d we=%0d want 1 0 1 0", i, ale, rd, lat, wc);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat, wc; logic [31:0] rd, md, da, dd; logic ale;
    int we_seen = 0;
    int rsp_seen = 0;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_we[0] || dbg_we[0]) we_seen++;
      if (rsp_valid[0]) rsp_seen++;
    end
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL abort_ready_in_rst: got %b want 0", req_ready[0]);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we[0] || dbg_we[0]) we_seen++;
      if (rsp_valid[0]) rsp_seen++;
    end
    total++;
    if (we_seen != 0 || rsp_seen != 0) begin
      bad++; $display("FAIL abort_quiet: got we=%0d rsp=%0d want 0 0", we_seen, rsp_seen);
    end
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, ale, wc, md, da, dd);
    total++;
    if (rd !== 32'h1000_0008 || lat != 3) begin
      bad++; $display("FAIL abort_readback: got %h lat=%0d want 10000008 3", rd, lat);
    end
  endtask

  task automatic test_back_to_back(input int g, input int lat);
    logic [31:0] adrs [4] = '{32'h10, 32'h11, 32'h16, 32'h1C};
    logic [1:0]  szs  [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic        unss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps [4] = '{32'h8899_AABB, 32'hFFFF_FFAA, 32'h0000_1000, 32'h0000_0007};
    int acc [4];
    int k = 0;
    int r = 0;
    int cyc = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = adrs[0]; req_size = szs[0]; req_uns = unss[0];
    req_valid[g] = 1'b1;
    while (r < 4 && cyc < 80) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (rsp_valid[g]) begin
        total++;
        if (rsp_rdata[g] !== exps[r] || cyc - acc[r] != lat + 2) begin
          bad++;
          $display("FAIL b2b_lat%0d_rsp%0d: got %h after %0d want %h after %0d",
                   lat, r, rsp_rdata[g], cyc - acc[r], exps[r], lat + 2);
        end
        r++;
      end
      if (req_ready[g] && k < 4) begin
        acc[k] = cyc;
        if (k > 0) begin
          total++;
          if (acc[k] - acc[k-1] != lat + 3) begin
            bad++;
            $display("FAIL b2b_lat%0d_gap%0d: got %0d want %0d", lat, k, acc[k] - acc[k-1], lat + 3);
          end
        end
        k++;
        @(posedge clk);
        #1;
        if (k < 4) begin
          req_addr = adrs[k]; req_size = szs[k]; req_uns = unss[k];
        end else begin
          req_valid[g] = 1'b0;
        end
      end
    end
    req_valid[g] = 1'b0;
    total++;
    if (r != 4 || k != 4) begin
      bad++; $display("FAIL b2b_lat%0d_count: got acc=%0d rsp=%0d want 4 4", lat, k, r);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_ale();
    test_reset_abort();
    test_back_to_back(1, 0);
    test_back_to_back(2, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
